// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. Owns the program counter, issues one outstanding
// request at a time to instruction memory and writes the IF/ID register.
//
// Handshake: imem_req is a one-cycle strobe that is high only in ISSUE, and
// imem_addr carries the address in that cycle. The memory returns exactly one
// imem_rvalid strobe per request, one or more cycles later, with imem_rdata
// valid in that same cycle. imem_rvalid in IDLE or ISSUE is ignored.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   prevent_update_pc           hazard hold (merged with the IF/ID hold)
//   prevent_update_reg_IF_ID    hazard hold (merged with the PC hold)
//   redirect_valid/redirect_pc  taken branch/jump from EX, flushes IF/ID
//   imem_req/imem_addr          fetch request strobe and address
//   imem_rvalid/imem_rdata      fetch response strobe and instruction
//   pc_IF_ID/instr_IF_ID        IF/ID register contents
//   valid_IF_ID                 IF/ID holds a real instruction
//   stall_count                 saturating count of stalled valid cycles
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int                 PC_W     = 64,
    parameter int                 INSTR_W  = 32,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP      = 32'h00000013,
    parameter int                 CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prevent_update_pc,
    input  logic               prevent_update_reg_IF_ID,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc_IF_ID,
    output logic [INSTR_W-1:0] instr_IF_ID,
    output logic               valid_IF_ID,
    output logic [CNT_W-1:0]   stall_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FULL  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic [PC_W-1:0]    pc_if_id_q, pc_if_id_d;
    logic [INSTR_W-1:0] instr_if_id_q, instr_if_id_d;
    logic               valid_if_id_q, valid_if_id_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;

    logic               stall;
    logic               load;
    logic [INSTR_W-1:0] load_data;

    assign stall = prevent_update_pc | prevent_update_reg_IF_ID;

    // Next state, PC and response buffer.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        load      = 1'b0;
        load_data = buf_q;
        case (state_q)
            IDLE: state_d = ISSUE;
            ISSUE: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        state_d = ISSUE;
                    end else if (stall) begin
                        buf_d   = imem_rdata;
                        state_d = FULL;
                    end else begin
                        load      = 1'b1;
                        load_data = imem_rdata;
                        pc_d      = pc_q + PC_W'(4);
                        state_d   = ISSUE;
                    end
                end else if (redirect_valid) begin
                    // Response still in flight: it must be swallowed in DRAIN.
                    pc_d    = redirect_pc;
                    state_d = DRAIN;
                end
            end
            FULL: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ISSUE;
                end else if (!stall) begin
                    load    = 1'b1;
                    pc_d    = pc_q + PC_W'(4);
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // IF/ID register: flush beats hold beats load beats bubble. pc_q is still
    // the fetch address of the loaded instruction because it advances on the
    // same edge.
    always_comb begin
        pc_if_id_d    = pc_if_id_q;
        instr_if_id_d = instr_if_id_q;
        valid_if_id_d = valid_if_id_q;
        if (redirect_valid) begin
            instr_if_id_d = NOP;
            valid_if_id_d = 1'b0;
        end else if (stall) begin
            // hold
        end else if (load) begin
            pc_if_id_d    = pc_q;
            instr_if_id_d = load_data;
            valid_if_id_d = 1'b1;
        end else begin
            instr_if_id_d = NOP;
            valid_if_id_d = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && valid_if_id_q && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            buf_q         <= '0;
            pc_if_id_q    <= '0;
            instr_if_id_q <= NOP;
            valid_if_id_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_q         <= buf_d;
            pc_if_id_q    <= pc_if_id_d;
            instr_if_id_q <= instr_if_id_d;
            valid_if_id_q <= valid_if_id_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign imem_req    = rst_n && (state_q == ISSUE);
    assign imem_addr   = pc_q;
    assign pc_IF_ID    = pc_if_id_q;
    assign instr_IF_ID = instr_if_id_q;
    assign valid_IF_ID = valid_if_id_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit with a behavioural instruction memory of
// programmable latency. A vector table covers straight-line fetch, hazard
// holds with buffering, and a flush that coincides with a hold. Hand-written
// sequences cover redirects into DRAIN, the PC wrap and stall_count
// saturation (CNT_W=4), and reset gating of imem_req.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int PC_W = 64;
  localparam int INSTR_W = 32;
  localparam int CNT_W = 4;
  localparam logic [INSTR_W-1:0] NOP = 32'h00000013;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               prevent_update_pc = 1'b0;
  logic               prevent_update_reg_IF_ID = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic [PC_W-1:0]    pc_IF_ID;
  logic [INSTR_W-1:0] instr_IF_ID;
  logic               valid_IF_ID;
  logic [CNT_W-1:0]   stall_count;

  if_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .prevent_update_pc(prevent_update_pc),
    .prevent_update_reg_IF_ID(prevent_update_reg_IF_ID),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .pc_IF_ID(pc_IF_ID),
    .instr_IF_ID(instr_IF_ID),
    .valid_IF_ID(valid_IF_ID),
    .stall_count(stall_count)
  );

  function automatic logic [INSTR_W-1:0] instr_at(input logic [PC_W-1:0] a);
    if (a == '0) return 32'h00A00093;
    return {16'hC0DE, a[15:0]};
  endfunction

  // memory model: response strobe lat cycles after the request cycle
  int lat = 1;
  int mcnt = 0;
  logic [PC_W-1:0] maddr = '0;
  always @(posedge clk) begin
    if (!rst_n) begin
      mcnt <= 0;
      imem_rvalid <= 1'b0;
      imem_rdata <= '0;
    end else if (imem_req) begin
      if (lat == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata <= instr_at(imem_addr);
        mcnt <= 0;
      end else begin
        imem_rvalid <= 1'b0;
        mcnt <= lat - 1;
        maddr <= imem_addr;
      end
    end else if (mcnt == 1) begin
      imem_rvalid <= 1'b1;
      imem_rdata <= instr_at(maddr);
      mcnt <= 0;
    end else begin
      imem_rvalid <= 1'b0;
      if (mcnt != 0) mcnt <= mcnt - 1;
    end
  end

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs applied for one cycle, outputs sampled 1 after the edge
  task automatic step(input logic s, input logic r, input logic [PC_W-1:0] rp);
    @(negedge clk);
    prevent_update_pc = s;
    prevent_update_reg_IF_ID = 1'b0;
    redirect_valid = r;
    redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [PC_W-1:0] addr,
                         input logic vld, input logic [INSTR_W-1:0] ins,
                         input logic [PC_W-1:0] pcid, input logic [CNT_W-1:0] cnt);
    chk({tag, ".imem_req"}, 64'(imem_req), 64'(req));
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".valid"}, 64'(valid_IF_ID), 64'(vld));
    chk({tag, ".instr"}, 64'(instr_IF_ID), 64'(ins));
    chk({tag, ".pc_IF_ID"}, pc_IF_ID, pcid);
    chk({tag, ".stall_count"}, 64'(stall_count), 64'(cnt));
  endtask

  typedef struct {
    logic               stall;
    logic               redir;
    logic [PC_W-1:0]    rpc;
    logic               req;
    logic [PC_W-1:0]    addr;
    logic               vld;
    logic [INSTR_W-1:0] ins;
    logic [PC_W-1:0]    pcid;
    logic [CNT_W-1:0]   cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    bit seen;
    // stall redir rpc | req addr vld instr pc_IF_ID stall_count
    tbl[0]  = '{0, 0, 0,     1, 0,     0, NOP,          0,     0};
    tbl[1]  = '{0, 0, 0,     0, 0,     0, NOP,          0,     0};
    tbl[2]  = '{0, 0, 0,     1, 4,     1, 32'h00A00093, 0,     0};
    tbl[3]  = '{0, 0, 0,     0, 4,     0, NOP,          0,     0};
    tbl[4]  = '{0, 0, 0,     1, 8,     1, instr_at(4),  4,     0};
    tbl[5]  = '{1, 0, 0,     0, 8,     1, instr_at(4),  4,     1};
    tbl[6]  = '{1, 0, 0,     0, 8,     1, instr_at(4),  4,     2};
    tbl[7]  = '{1, 0, 0,     0, 8,     1, instr_at(4),  4,     3};
    tbl[8]  = '{0, 0, 0,     1, 12,    1, instr_at(8),  8,     3};
    tbl[9]  = '{0, 0, 0,     0, 12,    0, NOP,          8,     3};
    tbl[10] = '{0, 0, 0,     1, 16,    1, instr_at(12), 12,    3};
    tbl[11] = '{1, 0, 0,     0, 16,    1, instr_at(12), 12,    4};
    tbl[12] = '{1, 0, 0,     0, 16,    1, instr_at(12), 12,    5};
    tbl[13] = '{1, 1, 'h40,  1, 'h40,  0, NOP,          12,    6};
    tbl[14] = '{0, 0, 0,     0, 'h40,  0, NOP,          12,    6};
    tbl[15] = '{0, 0, 0,     1, 'h44,  1, instr_at('h40), 'h40, 6};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 0, 1'b0, NOP, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      chk_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld,
              tbl[i].ins, tbl[i].pcid, tbl[i].cnt);
    end

    // redirect in WAIT with a 3-cycle memory; late response discarded
    lat = 3;
    step(0, 0, 0);
    step(0, 1, 'h100);
    chk("wait_redir.valid", 64'(valid_IF_ID), 0);
    chk("wait_redir.instr", 64'(instr_IF_ID), 64'(NOP));
    chk("wait_redir.addr", imem_addr, 'h100);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("drain_done.req", 64'(imem_req), 1);
    chk("drain_done.addr", imem_addr, 'h100);
    chk("drain_done.valid", 64'(valid_IF_ID), 0);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(0, 0, 0);
      seen = valid_IF_ID;
    end
    chk("redir_fetch.seen", 64'(seen), 1);
    chk("redir_fetch.pc", pc_IF_ID, 'h100);
    chk("redir_fetch.instr", 64'(instr_IF_ID), 64'(instr_at('h100)));

    // two redirects, the second arriving while already in DRAIN
    step(0, 0, 0);
    step(0, 1, 'h200);
    chk("drain1.addr", imem_addr, 'h200);
    step(0, 1, 'h300);
    chk("drain2.addr", imem_addr, 'h300);
    chk("drain2.req", 64'(imem_req), 0);
    step(0, 0, 0);
    chk("drain_exit.req", 64'(imem_req), 1);
    chk("drain_exit.addr", imem_addr, 'h300);

    // wrap of pc from all-ones-minus-3 to 0
    lat = 1;
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0);
    chk("wrap_issue.addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("wrap.pc_IF_ID", pc_IF_ID, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.instr", 64'(instr_IF_ID), 64'(instr_at(64'hFFFF_FFFF_FFFF_FFFC)));
    chk("wrap.addr", imem_addr, 0);

    // stall_count saturation: starts at 6, 20 stalled valid cycles
    for (int c = 0; c < 20; c++) begin
      step(1, 0, 0);
      if (c == 8) chk("sat9.count", 64'(stall_count), 15);
    end
    chk("sat20.count", 64'(stall_count), 15);
    chk("sat20.valid", 64'(valid_IF_ID), 1);
    step(0, 0, 0);
    chk("unstall.instr", 64'(instr_IF_ID), 64'(32'h00A00093));
    chk("unstall.pc", pc_IF_ID, 0);
    chk("unstall.addr", imem_addr, 4);
    chk("unstall.req", 64'(imem_req), 1);

    // reset asserted while in ISSUE: request gated immediately
    rst_n = 1'b0;
    #1;
    chk("rst_gate.req", 64'(imem_req), 0);
    @(posedge clk);
    #1;
    chk_all("rst_mid", 1'b0, 0, 1'b0, NOP, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
